module_display_arbiter: RTL and testbench
=========================================

MODULE_DISPLAY_ARBITER -- requirements
Module: module_display_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 SHALL have parameter HOLD_CYCLES, default 10_000_000, meaning the minimum grant time in clocks (1 s at 10 MHz, valid range >=1).
REQ-003 SHALL have parameter HOLD_BITS, default 24, meaning the hold-counter width.
REQ-004 SHALL have port clk_10Mhz_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req_i, input, N_REQ bits: per-requester display request, level, held while ownership is wanted.
REQ-007 SHALL have port data_i, input, N_REQ*32 bits: requester k value is at [32k+31:32k].
REQ-008 SHALL have port gnt_o, output, N_REQ bits: one-hot grant, or all-zero.
REQ-009 SHALL have port owner_o, output, $clog2(N_REQ) bits: index of the current or last owner.
REQ-010 SHALL have port display_o, output, 32 bits: registered value for the 7-segment controller display_i.
REQ-011 SHALL have port display_valid_o, output, 1 bit: high while gnt_o is non-zero.

Function
REQ-012 SHALL implement FSM states IDLE, HOLD and OPEN.
REQ-013 SHALL, in IDLE with req_i non-zero, grant the first requesting index at or after the round-robin pointer, wrapping modulo N_REQ, and enter HOLD with the hold counter = 0; gnt_o is high on the next edge.
REQ-014 SHALL, on every granted grant, set the pointer to (granted index + 1) mod N_REQ.
REQ-015 SHALL, while granted, load display_o from the owner's data_i slice every cycle (1-cycle latency).
REQ-016 SHALL, while not granted, hold display_o at its last value.
REQ-017 SHALL increment the hold counter in HOLD and go to OPEN when the counter == HOLD_CYCLES-1; HOLD_CYCLES=1 means OPEN one cycle after the grant.
REQ-018 SHALL, in OPEN with any non-owner request, hand off directly to the next requester in round-robin order: gnt_o changes old→new in one edge with no all-zero cycle, counter = 0, state HOLD.
REQ-019 SHALL, in OPEN with only the owner requesting, remain in OPEN with the grant unchanged.
REQ-020 SHALL, in HOLD, ignore non-owner requests (no preemption, except per REQ-027).
REQ-021 SHALL, when the owner drops req_i in HOLD or OPEN with other requests pending, hand off directly per REQ-018 next edge.
REQ-022 SHALL, when the owner drops req_i with no other requests pending, go to IDLE next edge with gnt_o=0 and display_valid_o=0.
REQ-023 SHALL keep gnt_o always one-hot or zero; display_valid_o == |gnt_o.

Reset
REQ-024 SHALL, while reset_n_i=0, asynchronously force state=IDLE, gnt_o=0, owner_o=0, display_o=32'h0, display_valid_o=0, hold counter=0 and pointer=0.
REQ-025 SHALL, on reset asserted mid-grant, clear per REQ-024 immediately; the first arbitration happens on the first edge after deassertion.

Configuration
REQ-026 SHALL use macro DISPLAY_ARB_PREEMPT_EN.
REQ-027 SHALL, when DISPLAY_ARB_PREEMPT_EN is defined, move the grant to requester 0 on the next edge whenever req_i[0]=1 and owner≠0 in HOLD or OPEN (counter=0, state HOLD, pointer=1).
REQ-028 SHALL, when DISPLAY_ARB_PREEMPT_EN is undefined, give requester 0 no priority beyond round-robin.

Structure
REQ-029 SHALL declare in package display_arb_pkg: the state enum (IDLE/HOLD/OPEN), the CLK_FREQ_HZ=10_000_000 constant and the default N_REQ.
REQ-030 SHALL place the round-robin selection (req vector + pointer → index + found flag) in combinational sub-module module_rr_picker.

Verification (HOLD_CYCLES=8, N_REQ=4)
REQ-031 SHALL verify reset: reset_n_i=0 mid-grant → all outputs 0 within the same cycle; first grant after release goes to the lowest requesting index.
REQ-032 SHALL verify a single grant: req_i=4'b0100 and data_i[95:64]=32'h1234_5678 → gnt_o=4'b0100 next edge, display_o=32'h1234_5678 one edge later, owner_o=2.
REQ-033 SHALL verify hold: owner 0 granted and req_i=4'b0011 from the grant cycle → gnt_o stays 4'b0001 for 8 cycles, then switches directly to 4'b0010 with no zero gap.
REQ-034 SHALL verify wrap-around: owner 3 in OPEN and req_i=4'b1001 → grant goes to 0, pointer=1.
REQ-035 SHALL verify release: the owner drops req alone → gnt_o=0 and display_valid_o=0 next edge, display_o holds its last value; the owner drops req while req 1 is pending → direct handoff to 1.
REQ-036 SHALL verify preemption with DISPLAY_ARB_PREEMPT_EN: owner 2 at hold counter 3 and req_i[0] rises → gnt_o=4'b0001 next edge; without the macro, the grant is held to the full 8 cycles.

Source files
------------

// File: rtl/display_arb_pkg.sv
// -----------------------------------------------------------------------------
// display_arb_pkg
// Shared definitions for the 7-segment display arbiter.
//   arb_state_t   : arbiter FSM states (IDLE / HOLD / OPEN)
//   CLK_FREQ_HZ   : system clock frequency. The default hold time is one
//                   second, which is CLK_FREQ_HZ cycles.
//   DEFAULT_N_REQ : default number of requesters
// -----------------------------------------------------------------------------
package display_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,   // nobody owns the display
      HOLD = 2'd1,   // owner inside its minimum grant window, not preemptable
      OPEN = 2'd2    // minimum window served, owner yields to any other request
   } arb_state_t;

   localparam int CLK_FREQ_HZ   = 10_000_000;
   localparam int DEFAULT_N_REQ = 4;

endpackage

// File: rtl/module_rr_picker.sv
// -----------------------------------------------------------------------------
// module_rr_picker
// Combinational round-robin selector. It returns the first set bit of req at
// or after index ptr, and wraps modulo N_REQ.
// Ports:
//   req   [N_REQ-1:0]         candidate request vector
//   ptr   [$clog2(N_REQ)-1:0] search start index (0..N_REQ-1)
//   idx   [$clog2(N_REQ)-1:0] selected index (0 when nothing is found)
//   found                     high when any bit of req is set
// -----------------------------------------------------------------------------
module module_rr_picker
   import display_arb_pkg::*;
#(
   parameter int N_REQ = DEFAULT_N_REQ
)(
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [$clog2(N_REQ)-1:0] idx,
   output logic                     found
);

   localparam int IDX_W = $clog2(N_REQ);

   int pos;

   // The loop walks from the furthest offset back to the nearest one.
   // The last hit written is therefore the one closest to ptr.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         pos = int'(ptr) + k;
         if (pos >= N_REQ) begin
            pos = pos - N_REQ;
         end
         if (req[IDX_W'(pos)]) begin
            idx   = IDX_W'(pos);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/module_display_arbiter.sv
// -----------------------------------------------------------------------------
// module_display_arbiter
// Round-robin arbiter that gives N_REQ requesters shared use of one 7-segment
// display controller. A new owner keeps the display for at least HOLD_CYCLES
// clocks. After that, any other request takes ownership directly, with no
// idle cycle between the two owners.
// Optional feature: define DISPLAY_ARB_PREEMPT_EN to let requester 0 preempt
// any other owner immediately, even inside the hold window.
// Ports:
//   clk_10Mhz_i     system clock, rising edge
//   reset_n_i       asynchronous active-low reset
//   req_i           [N_REQ]    level requests
//   data_i          [N_REQ*32] requester k value at [32k+31:32k]
//   gnt_o           [N_REQ]    one-hot grant or zero
//   owner_o         index of current / last owner
//   display_o       [32]       registered value of the owner's data
//   display_valid_o high while any grant is active
// -----------------------------------------------------------------------------
module module_display_arbiter
   import display_arb_pkg::*;
#(
   parameter int N_REQ       = DEFAULT_N_REQ,
   parameter int HOLD_CYCLES = CLK_FREQ_HZ,
   parameter int HOLD_BITS   = 24
)(
   input  logic                     clk_10Mhz_i,
   input  logic                     reset_n_i,
   input  logic [N_REQ-1:0]         req_i,
   input  logic [N_REQ*32-1:0]      data_i,
   output logic [N_REQ-1:0]         gnt_o,
   output logic [$clog2(N_REQ)-1:0] owner_o,
   output logic [31:0]              display_o,
   output logic                     display_valid_o
);

   localparam int OWNER_W = $clog2(N_REQ);

   arb_state_t           state_reg,   state_next;
   logic [N_REQ-1:0]     gnt_reg,     gnt_next;
   logic [OWNER_W-1:0]   owner_reg,   owner_next;
   logic [OWNER_W-1:0]   ptr_reg,     ptr_next;
   logic [HOLD_BITS-1:0] cnt_reg,     cnt_next;
   logic [31:0]          display_reg, display_next;

   logic [31:0]          data_slice [N_REQ];
   logic [N_REQ-1:0]     pick_req;
   logic [OWNER_W-1:0]   pick_idx;
   logic                 pick_found;
   logic                 owner_req;
   logic                 hold_done;
   logic                 do_grant;
   logic [OWNER_W-1:0]   grant_idx;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_slice
         assign data_slice[gi] = data_i[32*gi +: 32];
      end
   endgenerate

   // The owner is masked out of the candidate set, so the picker sees only
   // the other requesters. The pointer always sits just after the owner.
   // A handoff therefore follows round-robin order. In IDLE gnt_reg is zero,
   // so every request is a candidate.
   assign pick_req  = req_i & ~gnt_reg;
   assign owner_req = |(req_i & gnt_reg);
   assign hold_done = (cnt_reg == HOLD_BITS'(HOLD_CYCLES - 1));

   module_rr_picker #(
      .N_REQ (N_REQ)
   ) u_picker (
      .req   (pick_req),
      .ptr   (ptr_reg),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_comb begin
      state_next   = state_reg;
      gnt_next     = gnt_reg;
      owner_next   = owner_reg;
      ptr_next     = ptr_reg;
      cnt_next     = cnt_reg;
      do_grant     = 1'b0;
      grant_idx    = pick_idx;
      display_next = (|gnt_reg) ? data_slice[owner_reg] : display_reg;

      case (state_reg)
         IDLE: begin
            if (pick_found) begin
               do_grant = 1'b1;
            end
         end
         HOLD, OPEN: begin
`ifdef DISPLAY_ARB_PREEMPT_EN
            if (req_i[0] && (owner_reg != '0)) begin
               do_grant  = 1'b1;
               grant_idx = '0;
            end else
`endif
            if (!owner_req) begin
               // The owner let go. Hand off directly, or go idle.
               if (pick_found) begin
                  do_grant = 1'b1;
               end else begin
                  state_next = IDLE;
                  gnt_next   = '0;
               end
            end else if ((state_reg == OPEN) || hold_done) begin
               // On the last hold cycle the window has been served. The
               // arbiter then behaves as OPEN at this edge, so the owner
               // keeps the display for exactly HOLD_CYCLES clocks.
               if (pick_found) begin
                  do_grant = 1'b1;
               end else begin
                  state_next = OPEN;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            gnt_next   = '0;
         end
      endcase

      if (do_grant) begin
         state_next          = HOLD;
         cnt_next            = '0;
         owner_next          = grant_idx;
         gnt_next            = '0;
         gnt_next[grant_idx] = 1'b1;
         ptr_next            = (grant_idx == OWNER_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk_10Mhz_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_reg   <= IDLE;
         gnt_reg     <= '0;
         owner_reg   <= '0;
         ptr_reg     <= '0;
         cnt_reg     <= '0;
         display_reg <= 32'h0;
      end else begin
         state_reg   <= state_next;
         gnt_reg     <= gnt_next;
         owner_reg   <= owner_next;
         ptr_reg     <= ptr_next;
         cnt_reg     <= cnt_next;
         display_reg <= display_next;
      end
   end

   assign gnt_o           = gnt_reg;
   assign owner_o         = owner_reg;
   assign display_o       = display_reg;
   assign display_valid_o = |gnt_reg;

endmodule

// File: tb/tb_module_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_module_display_arbiter
// Self-checking bench for module_display_arbiter with N_REQ=4, HOLD_CYCLES=8.
// The bench honours DISPLAY_ARB_PREEMPT_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_module_display_arbiter;

   localparam int N = 4;
   localparam int H = 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [3:0]    req;
   logic [127:0]  data;
   logic [3:0]    gnt;
   logic [1:0]    owner;
   logic [31:0]   disp;
   logic          valid;

   int checks   = 0;
   int failures = 0;

   // Reference model state. It tracks ownership and the grant age in
   // cycles, not any FSM encoding.
   bit            m_owned;
   int            m_owner;
   int            m_ptr;
   int            m_age;
   logic [31:0]   m_disp;

   always #50 clk = ~clk;

   module_display_arbiter #(
      .N_REQ       (N),
      .HOLD_CYCLES (H),
      .HOLD_BITS   (24)
   ) dut (
      .clk_10Mhz_i     (clk),
      .reset_n_i       (reset_n),
      .req_i           (req),
      .data_i          (data),
      .gnt_o           (gnt),
      .owner_o         (owner),
      .display_o       (disp),
      .display_valid_o (valid)
   );

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  gnt;
      logic [1:0]  owner;
      logic        valid;
      logic [31:0] disp;
   } vec_t;

   localparam logic [127:0] DATA0 = {32'hDDDD_0003, 32'h1234_5678, 32'hBBBB_0001, 32'hAAAA_0000};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req     = 4'b0000;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic model_reset();
      m_owned = 1'b0;
      m_owner = 0;
      m_ptr   = 0;
      m_age   = 0;
      m_disp  = 32'h0;
   endtask

   task automatic model_grant(input int i);
      m_owned = 1'b1;
      m_owner = i;
      m_ptr   = (i + 1) % N;
      m_age   = 1;
   endtask

   // Advance the model by one clock edge, using the inputs that are
   // presented during the cycle before that edge.
   task automatic model_step(input logic [3:0] r, input logic [127:0] d);
      int  pick;
      int  cand;
      bit  preempt;
      pick = -1;
      if (m_owned) m_disp = d[32*m_owner +: 32];
      for (int k = 0; k < N; k++) begin
         cand = (m_ptr + k) % N;
         if (pick < 0 && r[cand] && !(m_owned && cand == m_owner)) pick = cand;
      end
`ifdef DISPLAY_ARB_PREEMPT_EN
      preempt = m_owned && r[0] && (m_owner != 0);
`else
      preempt = 1'b0;
`endif
      if (!m_owned) begin
         if (pick >= 0) model_grant(pick);
      end else if (preempt) begin
         model_grant(0);
      end else if (!r[m_owner]) begin
         if (pick >= 0) model_grant(pick);
         else m_owned = 1'b0;
      end else if (m_age >= H && pick >= 0) begin
         model_grant(pick);
      end else begin
         m_age++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t        tbl [9];
      logic [3:0]  exp_gnt;
      logic [3:0]  r;

      tbl[0] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 32'h0000_0000};
      tbl[1] = '{4'b0100, 4'b0100, 2'd2, 1'b1, 32'h0000_0000};
      tbl[2] = '{4'b0100, 4'b0100, 2'd2, 1'b1, 32'h1234_5678};
      tbl[3] = '{4'b0000, 4'b0000, 2'd2, 1'b0, 32'h1234_5678};
      tbl[4] = '{4'b0000, 4'b0000, 2'd2, 1'b0, 32'h1234_5678};
      tbl[5] = '{4'b1111, 4'b1000, 2'd3, 1'b1, 32'h1234_5678};
      tbl[6] = '{4'b1010, 4'b1000, 2'd3, 1'b1, 32'hDDDD_0003};
      tbl[7] = '{4'b0011, 4'b0001, 2'd0, 1'b1, 32'hDDDD_0003};
      tbl[8] = '{4'b0011, 4'b0001, 2'd0, 1'b1, 32'hAAAA_0000};

      data    = DATA0;
      req     = 4'b0000;
      reset_n = 1'b0;
      #1;
      chk("reset_gnt",   32'(gnt),   32'h0);
      chk("reset_valid", 32'(valid), 32'h0);
      chk("reset_disp",  disp,       32'h0);
      do_reset();

      // Table vectors: the expected outputs are sampled after each edge.
      for (int i = 0; i < 9; i++) begin
         req = tbl[i].req;
         tick();
         $display("vec %0d req=%b gnt=%b owner=%0d valid=%b disp=%h", i, req, gnt, owner, valid, disp);
         chk($sformatf("vec%0d_gnt", i),   32'(gnt),   32'(tbl[i].gnt));
         chk($sformatf("vec%0d_owner", i), 32'(owner), 32'(tbl[i].owner));
         chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(tbl[i].valid));
         chk($sformatf("vec%0d_disp", i),  disp,       tbl[i].disp);
      end

      // Hold window: owner 0 keeps the display for 8 cycles, then 1 takes over directly.
      do_reset();
      req = 4'b0011;
      for (int c = 1; c <= H; c++) begin
         tick();
         $display("hold cycle %0d gnt=%b", c, gnt);
         chk($sformatf("hold_c%0d", c), 32'(gnt), 32'h1);
      end
      tick();
      $display("hold handoff gnt=%b", gnt);
      chk("hold_handoff", 32'(gnt), 32'h2);

      // Wrap-around: owner 3 in OPEN hands off to 0, and the pointer moves to 1.
      do_reset();
      req = 4'b1000;
      repeat (H + 2) tick();
      chk("open_stay", 32'(gnt), 32'h8);
      req = 4'b1001;
      tick();
      $display("wrap gnt=%b owner=%0d", gnt, owner);
      chk("wrap_gnt",   32'(gnt),   32'h1);
      chk("wrap_owner", 32'(owner), 32'h0);
      req = 4'b0000;
      tick();
      chk("wrap_release", 32'(gnt), 32'h0);
      req = 4'b1111;
      tick();
      $display("ptr check gnt=%b", gnt);
      chk("ptr_after_wrap", 32'(gnt), 32'h2);

      // Release cases: a direct handoff, then a release with nobody pending.
      do_reset();
      req = 4'b0001;
      tick();
      tick();
      req = 4'b0010;
      tick();
      $display("drop handoff gnt=%b owner=%0d", gnt, owner);
      chk("drop_handoff", 32'(gnt),   32'h2);
      chk("drop_owner",   32'(owner), 32'h1);
      req = 4'b0000;
      tick();
      $display("release gnt=%b valid=%b disp=%h", gnt, valid, disp);
      chk("release_gnt",   32'(gnt),   32'h0);
      chk("release_valid", 32'(valid), 32'h0);
      chk("release_disp",  disp,       32'hBBBB_0001);
      data = {32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888};
      tick();
      chk("disp_hold", disp, 32'hBBBB_0001);
      data = DATA0;

      // Requester 0 rises while owner 2 is at hold count 3.
      do_reset();
      req = 4'b0100;
      repeat (4) tick();
      req = 4'b0101;
      tick();
`ifdef DISPLAY_ARB_PREEMPT_EN
      $display("preempt gnt=%b", gnt);
      chk("preempt_gnt", 32'(gnt), 32'h1);
`else
      chk("nopreempt_c5", 32'(gnt), 32'h4);
      for (int c = 6; c <= H; c++) begin
         tick();
         chk($sformatf("nopreempt_c%0d", c), 32'(gnt), 32'h4);
      end
      tick();
      $display("nopreempt expire gnt=%b", gnt);
      chk("nopreempt_expire", 32'(gnt), 32'h1);
`endif

      // Reset asserted mid-grant clears the outputs immediately.
      do_reset();
      req = 4'b0100;
      tick();
      tick();
      #20;
      reset_n = 1'b0;
      #1;
      $display("async reset gnt=%b owner=%0d valid=%b disp=%h", gnt, owner, valid, disp);
      chk("arst_gnt",   32'(gnt),   32'h0);
      chk("arst_owner", 32'(owner), 32'h0);
      chk("arst_valid", 32'(valid), 32'h0);
      chk("arst_disp",  disp,       32'h0);
      req = 4'b0110;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      chk("first_after_reset", 32'(gnt), 32'h2);

      // Randomized sticky requests, checked against the reference model.
      do_reset();
      model_reset();
      r = 4'b0000;
      for (int t = 0; t < 400; t++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
         end
         req  = r;
         data = {$urandom, $urandom, $urandom, $urandom};
         model_step(req, data);
         tick();
         exp_gnt = m_owned ? (4'b0001 << m_owner) : 4'b0000;
         $display("rnd %0d req=%b gnt=%b owner=%0d disp=%h", t, req, gnt, owner, disp);
         chk($sformatf("rnd%0d_ctl", t), {25'd0, gnt, owner, valid},
             {25'd0, exp_gnt, 2'(m_owner), m_owned});
         chk($sformatf("rnd%0d_disp", t), disp, m_disp);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
